// File: rtl/str_ops_pkg.sv
// Shared types for the string engine: op codes, compare codes, FSM states
// and the ASCII lowercase helper.
package str_ops_pkg;

  typedef enum logic [2:0] {
    OP_CLEAR   = 3'd0,
    OP_APPEND  = 3'd1,
    OP_PUTC    = 3'd2,
    OP_GETC    = 3'd3,
    OP_LEN     = 3'd4,
    OP_TOLOWER = 3'd5,
    OP_COMPARE = 3'd6,
    OP_CONCAT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    CMP_EQUAL   = 2'd0,
    CMP_LESS    = 2'd1,
    CMP_GREATER = 2'd2
  } cmp_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_COMMIT,
    S_RESP
  } state_e;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5a) begin
      return c + 8'h20;
    end
    return c;
  endfunction

endpackage

// File: rtl/str_slot_mem.sv
// String slot storage: NUM_STR x MAX_LEN chars plus per-slot lengths.
// Ports: two async read ports (char+len), one char/len write port, one whole-slot commit.
module str_slot_mem #(
  parameter int NUM_STR = 4,
  parameter int MAX_LEN = 16,
  parameter int CHAR_W  = 8,
  parameter int SW      = 2,
  parameter int IW      = 4,
  parameter int LW      = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SW-1:0]             ra_slot,
  input  logic [IW-1:0]             ra_idx,
  output logic [CHAR_W-1:0]         ra_char,
  output logic [LW-1:0]             ra_len,
  input  logic [SW-1:0]             rb_slot,
  input  logic [IW-1:0]             rb_idx,
  output logic [CHAR_W-1:0]         rb_char,
  output logic [LW-1:0]             rb_len,
  input  logic [SW-1:0]             w_slot,
  output logic [LW-1:0]             w_len,
  input  logic                      w_char_en,
  input  logic [IW-1:0]             w_idx,
  input  logic [CHAR_W-1:0]         w_char,
  input  logic                      w_len_en,
  input  logic [LW-1:0]             w_len_val,
  input  logic                      c_en,
  input  logic [MAX_LEN*CHAR_W-1:0] c_data,
  input  logic [LW-1:0]             c_len
);

  logic [CHAR_W-1:0] mem_q [NUM_STR][MAX_LEN];
  logic [LW-1:0]     len_q [NUM_STR];
  logic [LW-1:0]     len_d [NUM_STR];

  assign ra_char = mem_q[ra_slot][ra_idx];
  assign rb_char = mem_q[rb_slot][rb_idx];
  assign ra_len  = len_q[ra_slot];
  assign rb_len  = len_q[rb_slot];
  assign w_len   = len_q[w_slot];

  always_ff @(posedge clk) begin
    if (c_en) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_q[w_slot][i] <= c_data[i*CHAR_W +: CHAR_W];
      end
    end else if (w_char_en) begin
      mem_q[w_slot][w_idx] <= w_char;
    end
  end

  always_comb begin
    len_d = len_q;
    if (c_en) begin
      len_d[w_slot] = c_len;
    end else if (w_len_en) begin
      len_d[w_slot] = w_len_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STR; i++) begin
        len_q[i] <= '0;
      end
    end else begin
      len_q <= len_d;
    end
  end

endmodule

// File: rtl/str_ops_engine.sv
// String engine: SV-style string methods on NUM_STR slots behind valid/ready.
// Ports: cmd_* command in (valid/ready), rsp_* response out (valid/ready).
module str_ops_engine
  import str_ops_pkg::*;
#(
  parameter  int NUM_STR = 4,
  parameter  int MAX_LEN = 16,
  parameter  int CHAR_W  = 8,
  localparam int SW      = $clog2(NUM_STR),
  localparam int IW      = $clog2(MAX_LEN),
  localparam int LW      = IW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [SW-1:0]     cmd_dst,
  input  logic [SW-1:0]     cmd_src_a,
  input  logic [SW-1:0]     cmd_src_b,
  input  logic [IW-1:0]     cmd_idx,
  input  logic [CHAR_W-1:0] cmd_char,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CHAR_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int NS2 = 1 << SW;
  localparam logic [NS2-1:0] SLOT_OK = NS2'((64'd1 << NUM_STR) - 64'd1);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  cmp_e   tie_q, tie_d;
  logic [SW-1:0] dst_q, dst_d;
  logic [SW-1:0] a_q, a_d;
  logic [SW-1:0] b_q, b_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] n_q, n_d;
  logic [LW-1:0] la_q, la_d;
  logic [MAX_LEN*CHAR_W-1:0] scr_q, scr_d;
  logic [CHAR_W-1:0] data_q, data_d;
  logic err_q, err_d;

  logic [SW-1:0]     ra_slot, rb_slot, w_slot;
  logic [IW-1:0]     ra_idx, rb_idx, w_idx;
  logic [CHAR_W-1:0] ra_char, rb_char, w_char;
  logic [LW-1:0]     ra_len, rb_len, w_len, w_len_val;
  logic              w_char_en, w_len_en, c_en;

  op_e           op_in;
  logic          need_d, need_a, need_b, slots_ok;
  logic [IW+1:0] sum_ab;
  logic          cat_ovf;
  logic [LW-1:0] cat_len, min_ab, cat_off;
  logic          done, active;
  logic [CHAR_W-1:0] run_ch;

  str_slot_mem #(
    .NUM_STR (NUM_STR),
    .MAX_LEN (MAX_LEN),
    .CHAR_W  (CHAR_W),
    .SW      (SW),
    .IW      (IW),
    .LW      (LW)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .ra_slot   (ra_slot),
    .ra_idx    (ra_idx),
    .ra_char   (ra_char),
    .ra_len    (ra_len),
    .rb_slot   (rb_slot),
    .rb_idx    (rb_idx),
    .rb_char   (rb_char),
    .rb_len    (rb_len),
    .w_slot    (w_slot),
    .w_len     (w_len),
    .w_char_en (w_char_en),
    .w_idx     (w_idx),
    .w_char    (w_char),
    .w_len_en  (w_len_en),
    .w_len_val (w_len_val),
    .c_en      (c_en),
    .c_data    (scr_q),
    .c_len     (n_q)
  );

  assign op_in  = op_e'(cmd_op);
  assign need_d = op_in inside {OP_CLEAR, OP_APPEND, OP_PUTC,
                                OP_TOLOWER, OP_CONCAT};
  assign need_a = op_in inside {OP_GETC, OP_LEN, OP_TOLOWER,
                                OP_COMPARE, OP_CONCAT};
  assign need_b = op_in inside {OP_COMPARE, OP_CONCAT};
  assign slots_ok = (!need_d || SLOT_OK[cmd_dst]) &&
                    (!need_a || SLOT_OK[cmd_src_a]) &&
                    (!need_b || SLOT_OK[cmd_src_b]);

  // Sum is one bit wider than a length so it never wraps before clamping.
  assign sum_ab  = (IW+2)'(ra_len) + (IW+2)'(rb_len);
  assign cat_ovf = sum_ab > (IW+2)'(MAX_LEN);
  assign cat_len = cat_ovf ? LW'(MAX_LEN) : sum_ab[LW-1:0];
  assign min_ab  = (ra_len < rb_len) ? ra_len : rb_len;
  assign cat_off = cnt_q - la_q;

  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tie_d     = tie_q;
    dst_d     = dst_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    la_d      = la_q;
    scr_d     = scr_q;
    data_d    = data_q;
    err_d     = err_q;
    ra_slot   = cmd_src_a;
    ra_idx    = cmd_idx;
    rb_slot   = cmd_src_b;
    rb_idx    = '0;
    w_slot    = cmd_dst;
    w_idx     = cmd_idx;
    w_char    = cmd_char;
    w_char_en = 1'b0;
    w_len_en  = 1'b0;
    w_len_val = '0;
    c_en      = 1'b0;
    done      = 1'b0;
    active    = 1'b0;
    run_ch    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_in;
          dst_d   = cmd_dst;
          a_d     = cmd_src_a;
          b_d     = cmd_src_b;
          cnt_d   = '0;
          data_d  = '0;
          err_d   = 1'b0;
          state_d = S_RESP;
          if (!slots_ok) begin
            err_d = 1'b1;
          end else begin
            unique case (op_in)
              OP_CLEAR: begin
                w_len_en = 1'b1;
              end
              OP_APPEND: begin
                if (w_len == LW'(MAX_LEN) || cmd_char == '0) begin
                  err_d = 1'b1;
                end else begin
                  w_char_en = 1'b1;
                  w_idx     = w_len[IW-1:0];
                  w_len_en  = 1'b1;
                  w_len_val = w_len + LW'(1);
                end
              end
              OP_PUTC: begin
                if ({1'b0, cmd_idx} >= w_len || cmd_char == '0) begin
                  err_d = 1'b1;
                end else begin
                  w_char_en = 1'b1;
                end
              end
              OP_GETC: begin
                if ({1'b0, cmd_idx} >= ra_len) begin
                  err_d = 1'b1;
                end else begin
                  data_d = ra_char;
                end
              end
              OP_LEN: begin
                data_d = CHAR_W'(ra_len);
              end
              OP_TOLOWER: begin
                n_d     = ra_len;
                state_d = S_RUN;
              end
              OP_COMPARE: begin
                n_d     = min_ab;
                tie_d   = (ra_len < rb_len) ? CMP_LESS :
                          (ra_len > rb_len) ? CMP_GREATER : CMP_EQUAL;
                state_d = S_RUN;
              end
              OP_CONCAT: begin
                la_d    = ra_len;
                n_d     = cat_len;
                err_d   = cat_ovf;
                state_d = S_RUN;
              end
              default: ;
            endcase
          end
        end
      end
      S_RUN: begin
        ra_slot = a_q;
        ra_idx  = cnt_q[IW-1:0];
        rb_slot = b_q;
        rb_idx  = (op_q == OP_CONCAT) ? cat_off[IW-1:0] :
                                        cnt_q[IW-1:0];
        active  = cnt_q < n_q;
        // An empty operand still spends one cycle here.
        done    = (cnt_q + LW'(1)) >= n_q;
        cnt_d   = cnt_q + LW'(1);
        run_ch  = (op_q == OP_TOLOWER) ? to_lower(ra_char) :
                  (cnt_q < la_q) ? ra_char : rb_char;
        if (op_q == OP_COMPARE) begin
          if (done) begin
            data_d = CHAR_W'(tie_q);
          end
          if (active && ra_char != rb_char) begin
            data_d = (ra_char < rb_char) ? CHAR_W'(CMP_LESS) :
                                           CHAR_W'(CMP_GREATER);
            done   = 1'b1;
          end
        end else if (active) begin
          scr_d[cnt_q[IW-1:0]*CHAR_W +: CHAR_W] = run_ch;
        end
        if (done) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        // Sources stay untouched until here, so dst may alias a or b.
        w_slot  = dst_q;
        c_en    = (op_q != OP_COMPARE);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_CLEAR;
      tie_q   <= CMP_EQUAL;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      la_q    <= '0;
      scr_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tie_q   <= tie_d;
      dst_q   <= dst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      la_q    <= la_d;
      scr_q   <= scr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_str_ops_engine.sv
// Self-checking bench for str_ops_engine: directed vector table,
// hold/reset sequences and random commands against a queue-based model.
module tb_str_ops_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [1:0] cmd_dst = '0;
  logic [1:0] cmd_src_a = '0;
  logic [1:0] cmd_src_b = '0;
  logic [3:0] cmd_idx = '0;
  logic [7:0] cmd_char = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;

  always #5 clk = ~clk;

  str_ops_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dst   (cmd_dst),
    .cmd_src_a (cmd_src_a),
    .cmd_src_b (cmd_src_b),
    .cmd_idx   (cmd_idx),
    .cmd_char  (cmd_char),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  typedef struct {
    int         op;
    int         dst;
    int         a;
    int         b;
    int         idx;
    logic [7:0] ch;
    logic [7:0] d;
    logic       e;
    int         lat;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] mdl[4][$];
  int         n_pass = 0;
  int         n_tot = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  function automatic vec_t mk(input int op, dst, a, b, idx,
                              input logic [7:0] ch, input logic [7:0] d,
                              input logic e, input int lat);
    vec_t v;
    v.op = op; v.dst = dst; v.a = a; v.b = b; v.idx = idx;
    v.ch = ch; v.d = d; v.e = e; v.lat = lat;
    return v;
  endfunction

  // Reference: strings as byte queues, results from the method definitions.
  function automatic void ref_cmd(input int op, dst, a, b, idx,
                                  input logic [7:0] ch,
                                  output logic [7:0] d, output logic e,
                                  output int lat);
    logic [7:0] sa[$];
    logic [7:0] sb[$];
    logic [7:0] t[$];
    int n, m;
    sa = mdl[a];
    sb = mdl[b];
    d = 8'd0; e = 1'b0; lat = 1; n = 0;
    case (op)
      0: mdl[dst].delete();
      1: if (mdl[dst].size() == 16 || ch == 8'd0) e = 1'b1;
         else mdl[dst].push_back(ch);
      2: if (idx >= mdl[dst].size() || ch == 8'd0) e = 1'b1;
         else mdl[dst][idx] = ch;
      3: if (idx >= sa.size()) e = 1'b1;
         else d = sa[idx];
      4: d = 8'(sa.size());
      5: begin
        foreach (sa[i])
          t.push_back((sa[i] >= 8'h41 && sa[i] <= 8'h5a) ?
                      sa[i] + 8'd32 : sa[i]);
        n = sa.size();
        mdl[dst] = t;
      end
      6: begin
        m = (sa.size() < sb.size()) ? sa.size() : sb.size();
        n = m;
        d = (sa.size() < sb.size()) ? 8'd1 :
            (sa.size() > sb.size()) ? 8'd2 : 8'd0;
        for (int i = 0; i < m; i++) begin
          if (sa[i] != sb[i]) begin
            d = (sa[i] < sb[i]) ? 8'd1 : 8'd2;
            n = i + 1;
            break;
          end
        end
      end
      default: begin
        t = sa;
        foreach (sb[i]) t.push_back(sb[i]);
        if (t.size() > 16) e = 1'b1;
        while (t.size() > 16) void'(t.pop_back());
        n = t.size();
        mdl[dst] = t;
      end
    endcase
    if (op >= 5) lat = 2 + ((n < 1) ? 1 : n);
  endfunction

  task automatic do_cmd(input int op, dst, a, b, idx, input logic [7:0] ch,
                        output logic [7:0] d, output logic e,
                        output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      n_tot++;
      $display("FAIL cmd_ready_timeout: got 0, expected 1");
    end
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_dst   = 2'(dst);
    cmd_src_a = 2'(a);
    cmd_src_b = 2'(b);
    cmd_idx   = 4'(idx);
    cmd_char  = ch;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) begin
      n_tot++;
      $display("FAIL rsp_timeout: got 0, expected 1");
    end
    d = rsp_data;
    e = rsp_err;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic run_mdl(input string nm, input int op, dst, a, b, idx,
                         input logic [7:0] ch);
    logic [7:0] ed, gd;
    logic ee, ge;
    int el, gl;
    ref_cmd(op, dst, a, b, idx, ch, ed, ee, el);
    do_cmd(op, dst, a, b, idx, ch, gd, ge, gl);
    chk($sformatf("%s_op%0d_data", nm, op), int'(gd), int'(ed));
    chk($sformatf("%s_op%0d_err", nm, op), int'(ge), int'(ee));
    chk($sformatf("%s_op%0d_lat", nm, op), gl, el);
  endtask

  task automatic load(input int slot, input string s);
    run_mdl("ld", 0, slot, 0, 0, 0, 8'd0);
    for (int i = 0; i < s.len(); i++)
      run_mdl("ld", 1, slot, 0, 0, 0, s[i]);
  endtask

  logic [7:0] gd, md;
  logic ge, me;
  int gl, ml, w;

  initial begin
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 8, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 2, 0, 8'h67, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 8, 0, 0, 1, 1));
    tbl.push_back(mk(2, 0, 0, 0, 3, "d", 0, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 3, 0, 8'h64, 0, 1));
    tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 10));
    tbl.push_back(mk(3, 0, 0, 0, 0, 0, 8'h61, 0, 1));
    tbl.push_back(mk(2, 0, 0, 0, 8, "x", 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 1, 1));
    tbl.push_back(mk(6, 0, 1, 2, 0, 0, 2, 0, 3));
    tbl.push_back(mk(6, 0, 2, 1, 0, 0, 1, 0, 3));
    tbl.push_back(mk(6, 0, 1, 1, 0, 0, 0, 0, 8));
    tbl.push_back(mk(6, 0, 3, 1, 0, 0, 1, 0, 5));
    tbl.push_back(mk(6, 0, 1, 3, 0, 0, 2, 0, 5));
    tbl.push_back(mk(7, 0, 1, 2, 0, 0, 0, 0, 16));
    tbl.push_back(mk(4, 0, 0, 0, 0, 0, 14, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 6, 0, 8'h41, 0, 1));
    tbl.push_back(mk(3, 0, 0, 0, 13, 0, 8'h6c, 0, 1));
    tbl.push_back(mk(5, 2, 0, 0, 0, 0, 0, 0, 16));
    tbl.push_back(mk(3, 0, 2, 0, 6, 0, 8'h61, 0, 1));
    tbl.push_back(mk(7, 1, 1, 1, 0, 0, 0, 0, 14));
    tbl.push_back(mk(7, 1, 1, 1, 0, 0, 0, 1, 18));
    tbl.push_back(mk(7, 1, 1, 1, 0, 0, 0, 1, 18));
    tbl.push_back(mk(4, 0, 1, 0, 0, 0, 16, 0, 1));
    tbl.push_back(mk(3, 0, 1, 0, 15, 0, 8'h68, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, "x", 0, 1, 1));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(6, 0, 3, 3, 0, 0, 0, 0, 3));
    tbl.push_back(mk(6, 0, 3, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(5, 2, 3, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(4, 0, 2, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(7, 2, 3, 3, 0, 0, 0, 0, 3));
    tbl.push_back(mk(4, 0, 2, 0, 0, 0, 0, 0, 1));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    load(0, "Aggarwal");
    load(1, "Raghav");
    load(2, "Aggarwal");
    load(3, "Rag");

    foreach (tbl[i]) begin
      ref_cmd(tbl[i].op, tbl[i].dst, tbl[i].a, tbl[i].b, tbl[i].idx,
              tbl[i].ch, md, me, ml);
      do_cmd(tbl[i].op, tbl[i].dst, tbl[i].a, tbl[i].b, tbl[i].idx,
             tbl[i].ch, gd, ge, gl);
      chk($sformatf("vec%0d_data", i), int'(gd), int'(tbl[i].d));
      chk($sformatf("vec%0d_err", i), int'(ge), int'(tbl[i].e));
      chk($sformatf("vec%0d_lat", i), gl, tbl[i].lat);
    end

    // Response held while rsp_ready stays low.
    void'(mdl[1].size());
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd1; cmd_dst = 2'd1; cmd_char = "z";
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("hold_first_valid", int'(rsp_valid), 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_err", int'(rsp_err), 1);
      chk("hold_data", int'(rsp_data), 0);
      chk("hold_cmd_ready", int'(cmd_ready), 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("hold_release_valid", int'(rsp_valid), 0);
    chk("hold_release_ready", int'(cmd_ready), 1);

    // Reset in the middle of a CONCAT.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd7; cmd_dst = 2'd0; cmd_src_a = 2'd1; cmd_src_b = 2'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", int'(cmd_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_rsp_data", int'(rsp_data), 0);
    chk("mid_rst_rsp_err", int'(rsp_err), 0);
    for (int s = 0; s < 4; s++) mdl[s].delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) run_mdl("post_rst_len", 4, 0, s, 0, 0, 0);

    // Random commands against the model.
    for (int it = 0; it < 400; it++) begin
      int r, op, cs;
      logic [7:0] ch;
      r  = $urandom_range(0, 11);
      op = (r < 4) ? 1 : r - 4;
      cs = $urandom_range(0, 7);
      if (cs == 0) ch = 8'h00;
      else if (cs <= 3) ch = 8'(8'h41 + $urandom_range(0, 2));
      else if (cs <= 5) ch = 8'(8'h61 + $urandom_range(0, 2));
      else ch = 8'($urandom_range(1, 255));
      run_mdl("rnd", op, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 15), ch);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
